// File: rtl/nmr_bstrm_pkg.sv
// Shared command-word format and capture FSM state type for the bitstream
// generator/capture pair. Both ends import these so the word layout lives in
// exactly one place.
package nmr_bstrm_pkg;

  // Bit positions inside a 128-bit command word
  localparam int PATTERN_BIT = 120;
  localparam int ALL1_BIT    = 121;
  localparam int ALL0_BIT    = 122;
  localparam int SEQEND_BIT  = 123;

  // Capture engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/nmr_bstrm_sync.sv
// Multi-flop synchronizer for a single asynchronous bit. The output is the
// last flop of the chain, so input-to-output latency is SYNC_STAGES cycles.
module nmr_bstrm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw input through the flop chain; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/nmr_bstrm_rle_capture.sv
// Run-length capture engine. Samples a synchronized bitstream and encodes
// each constant-level run as an all-1s / all-0s command word, written to RAM
// one cycle after the cycle that ends the run.
//
// RAM write handshake: there is no back-pressure. A write happens exactly on
// the cycles where SRAM_CS, SRAM_CLKEN and SRAM_WR are all high; on those
// cycles SRAM_ADDR/SRAM_WR_DAT are valid and SRAM_BYTEEN is all ones. On every
// other cycle the strobes, data and byte enables are zero.
module nmr_bstrm_rle_capture
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH        = 120,
  parameter int CNT_WIDTH         = 32,
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         STOP,
  input  logic                         IN,
  output logic                         DONE,
  output logic                         OVERFLOW,
  output logic [SRAM_ADDR_WIDTH:0]     WORD_CNT,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_CS,
  output logic                         SRAM_CLKEN,
  output logic                         SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
  output logic [1:0]                   DBG_STATE
);

  localparam logic [CNT_WIDTH-1:0]       LEN_MAX   = '1;
  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;

  cap_state_t                 state;
  logic                       in_s;
  logic                       level;
  logic [CNT_WIDTH-1:0]       len;
  logic [SRAM_ADDR_WIDTH-1:0] ptr;
  logic [SRAM_ADDR_WIDTH:0]   word_cnt;
  logic                       overflow;
  logic                       done_r;
  logic                       wr_en;
  logic [SRAM_DAT_WIDTH-1:0]  wr_dat;

  logic [SRAM_ADDR_WIDTH-1:0] emit_addr;
  logic                       run_ends;
  logic                       full;

  nmr_bstrm_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (IN),
    .q  (in_s)
  );

  // Assemble one command word from a run's level and length
  function automatic logic [SRAM_DAT_WIDTH-1:0] make_word(
    input logic                 lvl,
    input logic [CNT_WIDTH-1:0] ln,
    input logic                 seq_end
  );
    logic [SRAM_DAT_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0]     data;
    w                = '0;
    data             = DATA_WIDTH'(ln);
    w[DATA_WIDTH-1:0] = data;
    w[PATTERN_BIT]   = 1'b0;
    w[ALL1_BIT]      = lvl;
    w[ALL0_BIT]      = ~lvl;
    w[SEQEND_BIT]    = seq_end;
    return w;
  endfunction

  // A write still in flight bumps the pointer at its end, so the next emit
  // lands one address further on. Full means that emit would take the last
  // address of the RAM.
  always_comb begin
    emit_addr = ptr + SRAM_ADDR_WIDTH'(wr_en);
    run_ends  = (in_s != level) || (len == LEN_MAX);
    full      = (emit_addr == ADDR_LAST);
  end

  // Capture FSM, run counter, write pointer and registered RAM write port
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      level    <= 1'b0;
      len      <= '0;
      ptr      <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
      done_r   <= 1'b0;
      wr_en    <= 1'b0;
      wr_dat   <= '0;
    end else begin
      wr_en  <= 1'b0;
      wr_dat <= '0;

      // Pointer and count advance once the write cycle has completed; the
      // pointer sticks at the last address instead of wrapping.
      if (wr_en) begin
        word_cnt <= word_cnt + 1'b1;
        if (ptr != ADDR_LAST) begin
          ptr <= ptr + 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state    <= ST_RUN;
            ptr      <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
            done_r   <= 1'b0;
            level    <= in_s;
            len      <= CNT_WIDTH'(1);
          end
        end

        ST_RUN: begin
          if (STOP) begin
            // The sample present on the STOP cycle is not part of the run
            wr_en  <= 1'b1;
            wr_dat <= make_word(level, len, 1'b1);
            state  <= ST_FLUSH;
          end else if (run_ends) begin
            wr_en  <= 1'b1;
            wr_dat <= make_word(level, len, full);
            level  <= in_s;
            len    <= CNT_WIDTH'(1);
            if (full) begin
              overflow <= 1'b1;
              done_r   <= 1'b1;
              state    <= ST_DONE;
            end
          end else begin
            len <= len + 1'b1;
          end
        end

        ST_FLUSH: begin
          // The seq_end word is on the bus during this cycle
          done_r <= 1'b1;
          state  <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign DONE        = done_r;
  assign OVERFLOW    = overflow;
  assign WORD_CNT    = word_cnt;
  assign SRAM_ADDR   = ptr;
  assign SRAM_CS     = wr_en;
  assign SRAM_CLKEN  = wr_en;
  assign SRAM_WR     = wr_en;
  assign SRAM_WR_DAT = wr_dat;
  assign SRAM_BYTEEN = {SRAM_BYTEEN_WIDTH{wr_en}};
  assign DBG_STATE   = state;

endmodule

// File: tb/tb_nmr_bstrm_rle_capture.sv
// Bench for the run-length capture engine. Each capture's sample sequence is
// fixed up front; a run-length model turns it into the list of words, their
// addresses and the cycles they must appear on, and a per-cycle monitor
// compares the RAM port, DONE, OVERFLOW and WORD_CNT against that list.
module tb_nmr_bstrm_rle_capture;
  import nmr_bstrm_pkg::*;

  localparam int CW = 4;
  localparam int AW = 3;
  localparam int S  = 2;
  localparam int DW = 128;
  localparam int EW = 32 + AW + DW;
  localparam int LEN_MAX   = (1 << CW) - 1;
  localparam int ADDR_LAST = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          in_bit;
  logic          done;
  logic          overflow;
  logic [AW:0]   word_cnt;
  logic [AW-1:0] sram_addr;
  logic          sram_cs;
  logic          sram_clken;
  logic          sram_wr;
  logic [DW-1:0] sram_wr_dat;
  logic [15:0]   sram_byteen;
  logic [1:0]    dbg_state;

  nmr_bstrm_rle_capture #(
    .DATA_WIDTH(120), .CNT_WIDTH(CW), .SRAM_ADDR_WIDTH(AW),
    .SRAM_DAT_WIDTH(DW), .SRAM_BYTEEN_WIDTH(16), .SYNC_STAGES(S)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .IN(in_bit),
    .DONE(done), .OVERFLOW(overflow), .WORD_CNT(word_cnt),
    .SRAM_ADDR(sram_addr), .SRAM_CS(sram_cs), .SRAM_CLKEN(sram_clken),
    .SRAM_WR(sram_wr), .SRAM_WR_DAT(sram_wr_dat), .SRAM_BYTEEN(sram_byteen),
    .DBG_STATE(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_w[$];
  bit            mon_en = 1'b0;
  int            done_cyc;
  int            last_w;
  bit            exp_ovf;

  bit smp[0:63];
  int m_cnt;
  int m_len[0:15];
  bit m_lvl[0:15];
  bit m_end[0:15];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, cyc - 1);
    end
  endtask

  // Run-length model: split samples into runs (level change or max length),
  // assign addresses 0,1,2..., mark the last word, stop early on a full RAM.
  function automatic void model(input int c0, input int n);
    int i, ln, j, w, k;
    bit lvl, fin, se;
    logic [DW-1:0] word;
    logic [AW-1:0] a;
    exp_q.delete();
    exp_w.delete();
    m_cnt   = 0;
    exp_ovf = 1'b0;
    done_cyc = 0;
    i = 0;
    while (i < n) begin
      lvl = smp[i];
      ln  = 1;
      while ((i + ln < n) && (smp[i + ln] == lvl) && (ln < LEN_MAX)) ln++;
      j   = i + ln - 1;
      fin = (j == n - 1);
      k   = m_cnt;
      se  = fin || (k == ADDR_LAST);
      word = '0;
      word[CW-1:0] = CW'(ln);
      word[121] = lvl;
      word[122] = ~lvl;
      word[123] = se;
      w = c0 + j + 1;
      a = AW'(k);
      exp_q.push_back({w[31:0], a, word});
      exp_w.push_back(w);
      m_len[k] = ln;
      m_lvl[k] = lvl;
      m_end[k] = se;
      m_cnt++;
      last_w = w;
      if (fin) begin
        done_cyc = w + 1;
        break;
      end
      if (k == ADDR_LAST) begin
        exp_ovf  = 1'b1;
        done_cyc = w;
        break;
      end
      i = j + 1;
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  int            now;
  int            wc;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (mon_en) begin
      now = cyc - 1;
      if ((exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) == now)) begin
        e = exp_q.pop_front();
        check("wr", sram_wr, 1'b1);
        check("addr", sram_addr, e[AW+DW-1 -: AW]);
        check("data", sram_wr_dat, e[DW-1:0]);
        check("strobes", {sram_cs, sram_clken, sram_byteen}, {2'b11, 16'hffff});
      end else begin
        check("idle_bus", {sram_wr, sram_cs, sram_clken, |sram_wr_dat, |sram_byteen}, 5'b0);
      end
      check("done", done, (now >= done_cyc));
      check("overflow", overflow, (exp_ovf && (now >= last_w)));
      wc = 0;
      foreach (exp_w[q]) if (exp_w[q] < now) wc++;
      check("word_cnt", word_cnt, wc);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit s, input bit p, input bit b);
    start  = s;
    stop   = p;
    in_bit = b;
    @(posedge clk);
    #1;
  endtask

  // Drive a capture whose captured samples are smp[0..n-1]; STOP follows them.
  task automatic capture(input int n);
    int c0;
    c0 = cyc + S;
    model(c0, n);
    for (int k = 0; k <= S + n; k++) begin
      step(k == S, k == S + n, (k < n) ? smp[k] : 1'($urandom_range(0, 1)));
      if (k == S) mon_en = 1'b1;
    end
    for (int t = 0; (t < 50) && (cyc <= done_cyc + 2); t++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    mon_en = 1'b0;
    check("exp_drained", exp_q.size(), 0);
    check("done_end", done, 1'b1);
    check("word_cnt_end", word_cnt, m_cnt);
    check("overflow_end", overflow, exp_ovf);
  endtask

  // ---------------- main sequence ----------------
  int n, i, rl;
  bit lvl;
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_bus", {sram_wr, sram_cs, sram_clken, |sram_wr_dat, |sram_byteen}, 5'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    check("stop_in_idle", dbg_state, ST_IDLE);

    // 5 zeros then 3 ones
    for (int k = 0; k < 8; k++) smp[k] = (k >= 5);
    capture(8);
    check("m1_cnt", m_cnt, 2);
    check("m1_w0", {m_len[0], m_lvl[0], m_end[0]}, {32'd5, 1'b0, 1'b0});
    check("m1_w1", {m_len[1], m_lvl[1], m_end[1]}, {32'd3, 1'b1, 1'b1});
    check("t1_wcnt", word_cnt, 2);
    check("t1_ovf", overflow, 1'b0);

    // toggling every cycle for 6 cycles: six back-to-back writes
    for (int k = 0; k < 6; k++) smp[k] = ~k[0];
    capture(6);
    check("m2_cnt", m_cnt, 6);
    check("m2_span", exp_w[5] - exp_w[0], 5);
    check("t2_wcnt", word_cnt, 6);

    // 20 ones: saturates at 15, then 5
    for (int k = 0; k < 20; k++) smp[k] = 1'b1;
    capture(20);
    check("m3_cnt", m_cnt, 2);
    check("m3_w0", {m_len[0], m_lvl[0], m_end[0]}, {32'd15, 1'b1, 1'b0});
    check("m3_w1", {m_len[1], m_lvl[1], m_end[1]}, {32'd5, 1'b1, 1'b1});

    // alternating, STOP far too late: RAM fills
    for (int k = 0; k < 20; k++) smp[k] = k[0];
    capture(20);
    check("m4_cnt", m_cnt, 8);
    check("m4_ovf", exp_ovf, 1'b1);
    check("m4_last", m_end[7], 1'b1);
    check("t4_wcnt", word_cnt, 8);
    check("t4_addr", sram_addr, ADDR_LAST);

    // reset two cycles into a run
    for (int k = 0; k < S; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rr_state", dbg_state, ST_IDLE);
    check("rr_outs", {done, overflow, word_cnt, sram_addr}, 0);
    check("rr_bus", {sram_wr, sram_cs, sram_clken, |sram_wr_dat, |sram_byteen}, 5'b0);

    // capture after reset restarts from address 0
    for (int k = 0; k < 8; k++) smp[k] = (k >= 5);
    capture(8);

    // random captures
    for (int r = 0; r < 30; r++) begin
      n   = $urandom_range(1, 40);
      lvl = 1'($urandom_range(0, 1));
      i   = 0;
      while (i < n) begin
        rl = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 24) : $urandom_range(1, 4);
        for (int q = 0; (q < rl) && (i < n); q++) begin
          smp[i] = lvl;
          i++;
        end
        lvl = ~lvl;
      end
      capture(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
